// File: rtl/instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// instr_fetch_mem
//
// Byte-organised instruction memory with a request/busywait handshake.
// Sits upstream of the CPU and turns a PC into a 32-bit instruction word.
// A miss takes a multi-cycle fetch. A one-word last-fetch buffer lets a
// repeated fetch of the same word return after a single edge. A byte load
// port writes program bytes at any time.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   RESET        synchronous active-low reset (memory contents preserved)
//   READ         fetch request
//   ADDRESS      byte address. Bits [ADDR_W-1:2] select the word.
//   INSTRUCTION  fetched word, little-endian {b3,b2,b1,b0}
//   BUSYWAIT     high while a miss is outstanding, including the request cycle
//   VALID        one-cycle pulse when INSTRUCTION is updated by a fetch
//   LOAD_EN      byte write enable
//   LOAD_ADDR    byte write address
//   LOAD_DATA    byte write data
// ---------------------------------------------------------------------------
module instr_fetch_mem #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic [31:0]       ADDRESS,
    output logic [31:0]       INSTRUCTION,
    output logic              BUSYWAIT,
    output logic              VALID,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [7:0]        LOAD_DATA
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int CNT_W  = $clog2(LATENCY + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                buf_valid_q, buf_valid_d;
    logic [WORD_W-1:0]   buf_tag_q, buf_tag_d;
    logic [31:0]         buf_word_q, buf_word_d;

    logic [7:0]          mem_q [DEPTH];

    logic [WORD_W-1:0]   req_word;
    logic [WORD_W-1:0]   load_word;
    logic [WORD_W-1:0]   fetch_word;
    logic [31:0]         rd_word;
    logic                hit;
    logic                miss;
    logic                fetch_done;
    logic                unused_addr_bits;

    assign req_word  = ADDRESS[ADDR_W-1:2];
    assign load_word = LOAD_ADDR[ADDR_W-1:2];

    // Addresses are taken modulo DEPTH and the byte lane is ignored.
    assign unused_addr_bits = ^{ADDRESS[31:ADDR_W], ADDRESS[1:0]};

    assign hit  = (state_q == S_IDLE) && READ && buf_valid_q && (buf_tag_q == req_word);
    assign miss = (state_q == S_IDLE) && READ && !hit;

    // The request cycle counts as the first busy cycle. The fetch completes
    // on the edge that ends busy cycle LATENCY-1. With LATENCY==2 that is
    // the accepting edge itself, so FETCH is never entered.
    assign fetch_done = ((state_q == S_FETCH) && (cnt_q == CNT_W'(1)))
                      || ((LATENCY == 2) && miss);

    // During FETCH the latched word is used, so later ADDRESS changes are ignored.
    assign fetch_word = (state_q == S_FETCH) ? addr_q : req_word;

    // Assemble the little-endian word from four byte lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_word[8*gi +: 8] = mem_q[{fetch_word, 2'(gi)}];
        end
    endgenerate

    // Next-state logic and outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        valid_d     = 1'b0;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_word_d  = buf_word_q;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    instr_d = buf_word_q;
                    valid_d = 1'b1;
                end else if (miss) begin
                    addr_d = req_word;
                    if (LATENCY > 2) begin
                        state_d = S_FETCH;
                        // Number of FETCH edges still to come, including the completing one.
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            S_FETCH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fetch_done) begin
            // The array is read before this edge's byte write lands, so the
            // returned word carries the old bytes. The buffer must not keep them.
            instr_d     = rd_word;
            valid_d     = 1'b1;
            buf_tag_d   = fetch_word;
            buf_word_d  = rd_word;
            buf_valid_d = !(LOAD_EN && (load_word == fetch_word));
        end else if (LOAD_EN && buf_valid_q && (load_word == buf_tag_q)) begin
            buf_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_word_q  <= buf_word_d;
        end
    end

    // Byte write port. Contents survive reset, but reset blocks writes.
    always_ff @(posedge CLK) begin
        if (RESET && LOAD_EN) begin
            mem_q[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    assign INSTRUCTION = instr_q;
    assign VALID       = valid_q;
    // Gated by RESET so the stall is released while reset is held.
    assign BUSYWAIT    = RESET && (miss || (state_q == S_FETCH));

endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;

    localparam int DEPTH   = 1024;
    localparam int ADDR_W  = 10;
    localparam int LATENCY = 4;

    logic              CLK;
    logic              RESET;
    logic              READ;
    logic [31:0]       ADDRESS;
    logic [31:0]       INSTRUCTION;
    logic              BUSYWAIT;
    logic              VALID;
    logic              LOAD_EN;
    logic [ADDR_W-1:0] LOAD_ADDR;
    logic [7:0]        LOAD_DATA;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_fetch_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LATENCY(LATENCY)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .READ       (READ),
        .ADDRESS    (ADDRESS),
        .INSTRUCTION(INSTRUCTION),
        .BUSYWAIT   (BUSYWAIT),
        .VALID      (VALID),
        .LOAD_EN    (LOAD_EN),
        .LOAD_ADDR  (LOAD_ADDR),
        .LOAD_DATA  (LOAD_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        LOAD_EN   = 1'b1;
        LOAD_ADDR = a;
        LOAD_DATA = d;
        @(posedge CLK); #1;
        LOAD_EN   = 1'b0;
        $display("load  mem[%0d] <= %h", a, d);
    endtask

    // Miss: busy in the request cycle and two FETCH cycles, data after the 3rd edge.
    // ADDRESS is scrambled during FETCH to show the latched address is used.
    // Optionally a byte write is driven onto the completing edge.
    task automatic miss_seq(input string tag, input logic [31:0] a, input logic [31:0] exp,
                            input logic do_ld, input logic [ADDR_W-1:0] ld_a, input logic [7:0] ld_d);
        READ = 1'b1;
        ADDRESS = a;
        #1;
        chk({tag, "_busy_req"}, {31'd0, BUSYWAIT}, 32'd1);
        @(posedge CLK); #1;
        READ = 1'b0;
        ADDRESS = 32'h0000_0004 ^ a;
        #1;
        chk({tag, "_busy_f1"}, {31'd0, BUSYWAIT}, 32'd1);
        chk({tag, "_valid_f1"}, {31'd0, VALID}, 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_busy_f2"}, {31'd0, BUSYWAIT}, 32'd1);
        chk({tag, "_valid_f2"}, {31'd0, VALID}, 32'd0);
        if (do_ld) begin
            LOAD_EN   = 1'b1;
            LOAD_ADDR = ld_a;
            LOAD_DATA = ld_d;
        end
        @(posedge CLK); #1;
        LOAD_EN = 1'b0;
        chk({tag, "_instr"}, INSTRUCTION, exp);
        chk({tag, "_valid"}, {31'd0, VALID}, 32'd1);
        chk({tag, "_busy_done"}, {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_valid_drop"}, {31'd0, VALID}, 32'd0);
        $display("miss  addr=%h instr=%h expect=%h", a, INSTRUCTION, exp);
    endtask

    // Hit: BUSYWAIT stays low and the data arrives after one edge.
    task automatic hit_seq(input string tag, input logic [31:0] a, input logic [31:0] exp);
        READ = 1'b1;
        ADDRESS = a;
        #1;
        chk({tag, "_busy_req"}, {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        READ = 1'b0;
        #1;
        chk({tag, "_instr"}, INSTRUCTION, exp);
        chk({tag, "_valid"}, {31'd0, VALID}, 32'd1);
        chk({tag, "_busy"}, {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_valid_drop"}, {31'd0, VALID}, 32'd0);
        $display("hit   addr=%h instr=%h expect=%h", a, INSTRUCTION, exp);
    endtask

    initial begin
        RESET     = 1'b0;
        READ      = 1'b1;
        ADDRESS   = 32'h0;
        LOAD_EN   = 1'b0;
        LOAD_ADDR = '0;
        LOAD_DATA = 8'h00;

        // Step 1: reset held for two edges with a request pending.
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            chk("rst_instr", INSTRUCTION, 32'h0);
            chk("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
            chk("rst_valid", {31'd0, VALID}, 32'd0);
        end
        $display("reset instr=%h busy=%b valid=%b", INSTRUCTION, BUSYWAIT, VALID);
        READ  = 1'b0;
        RESET = 1'b1;

        // Step 2: program words 0x00000003@0, 0x00010005@4, 0x02020100@8.
        load_byte(10'd0,  8'h03); load_byte(10'd1,  8'h00);
        load_byte(10'd2,  8'h00); load_byte(10'd3,  8'h00);
        load_byte(10'd4,  8'h05); load_byte(10'd5,  8'h00);
        load_byte(10'd6,  8'h01); load_byte(10'd7,  8'h00);
        load_byte(10'd8,  8'h00); load_byte(10'd9,  8'h01);
        load_byte(10'd10, 8'h02); load_byte(10'd11, 8'h02);
        miss_seq("m0", 32'h0, 32'h0000_0003, 1'b0, '0, 8'h00);

        // Step 3: same word again hits.
        hit_seq("h0", 32'h0, 32'h0000_0003);

        // Step 4: sequential PC, then wrapped alias of word 2.
        miss_seq("m4", 32'h4, 32'h0001_0005, 1'b0, '0, 8'h00);
        miss_seq("m8", 32'h8, 32'h0202_0100, 1'b0, '0, 8'h00);
        hit_seq("h408", 32'h408, 32'h0202_0100);

        // Step 5: write into buffered word invalidates it.
        load_byte(10'd9, 8'hAA);
        // Byte 10 rewritten on the completing edge: old byte returned, buffer left invalid.
        miss_seq("m8w", 32'h8, 32'h0202_AA00, 1'b1, 10'd10, 8'h55);
        miss_seq("m8r", 32'h8, 32'h0255_AA00, 1'b0, '0, 8'h00);

        // Step 6: reset on the completing edge aborts the fetch.
        READ = 1'b1;
        ADDRESS = 32'h4;
        #1;
        chk("abort_busy_req", {31'd0, BUSYWAIT}, 32'd1);
        @(posedge CLK); #1;
        READ = 1'b0;
        #1;
        chk("abort_busy_f1", {31'd0, BUSYWAIT}, 32'd1);
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk("abort_valid", {31'd0, VALID}, 32'd0);
        chk("abort_busy", {31'd0, BUSYWAIT}, 32'd0);
        chk("abort_instr", INSTRUCTION, 32'h0);
        RESET = 1'b1;
        #1;
        chk("abort_busy_rel", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        chk("abort_valid_next", {31'd0, VALID}, 32'd0);
        chk("abort_instr_next", INSTRUCTION, 32'h0);
        $display("abort instr=%h busy=%b valid=%b", INSTRUCTION, BUSYWAIT, VALID);
        miss_seq("m4b", 32'h4, 32'h0001_0005, 1'b0, '0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
